// File: rtl/step_seq_pkg.sv
// Shared types and defaults for the step sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package step_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP,
        FAULT
    } state_t;

    localparam int STEP_GAP_DEF = 4;
    localparam int TIMEOUT_DEF  = 255;

    typedef logic [7:0] pos_t;
    typedef logic [3:0] gap_cnt_t;
    typedef logic [7:0] tmo_cnt_t;

endpackage

// File: rtl/step_sequencer_if.sv
// Command and motor-driver handshake bundle for the step sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd_ready qualifies cmd_valid; done answers each forw/rev.
interface step_sequencer_if;
    import step_seq_pkg::*;

    logic cmd_valid;
    pos_t cmd_target;
    logic cmd_ready;
    logic forw;
    logic rev;
    logic done;
    pos_t pos;
    logic busy;
    logic fault;

    // Command source / motor driver side
    modport master (
        output cmd_valid, cmd_target, done,
        input  cmd_ready, forw, rev, pos, busy, fault
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_target, done,
        output cmd_ready, forw, rev, pos, busy, fault
    );

endinterface

// File: rtl/step_sequencer_pos_cmp.sv
// Unsigned magnitude compare of target against current position.
// Latency: combinational.
// Backpressure: none.
module pos_cmp
    import step_seq_pkg::*;
(
    input  pos_t a,
    input  pos_t b,
    output logic gt,
    output logic lt,
    output logic eq
);

    logic [8:0] diff;

    // Borrow out of a-b means a<b; zero difference means equal.
    assign diff = {1'b0, a} - {1'b0, b};
    assign lt   = diff[8];
    assign eq   = (diff[7:0] == 8'd0);
    assign gt   = !diff[8] && !eq;

endmodule

// File: rtl/step_sequencer.sv
// Walks pos one step at a time toward a commanded target via forw/rev/done.
// Latency: accept->first step 1 cycle; done->next step STEP_GAP+1 cycles.
// Backpressure: cmd_ready only in IDLE; commands while busy are dropped. Optional STEP_TIMEOUT_EN adds done timeout -> FAULT.
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int STEP_GAP = STEP_GAP_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic            drv_clk,
    input  logic            reset,
    step_sequencer_if.slave bus
);

    // Out-of-range configuration leaves the block refusing commands rather than mis-timing steps.
    localparam bit CFG_OK = (STEP_GAP >= 1) && (STEP_GAP <= 15) &&
                            (TIMEOUT >= 2) && (TIMEOUT <= 255);

    state_t   state;
    state_t   state_nxt;
    pos_t     pos_q;
    pos_t     target_q;
    logic     dir_fwd_q;
    gap_cnt_t gap_cnt;
    pos_t     cmp_a;
    logic     cmp_gt;
    logic     cmp_lt;
    logic     cmp_eq;
    logic     accept;
    logic     gap_last;
    logic     tmo_hit;

    logic     cmd_ready_o;
    logic     busy_o;
    logic     forw_o;
    logic     rev_o;
    logic     fault_o;

    // While idle the incoming target is compared so an equal command never leaves IDLE.
    assign cmp_a    = (state == IDLE) ? bus.cmd_target : target_q;
    assign accept   = (state == IDLE) && bus.cmd_valid && CFG_OK;
    assign gap_last = (gap_cnt == gap_cnt_t'(STEP_GAP - 1));

    pos_cmp u_pos_cmp (
        .a  (cmp_a),
        .b  (pos_q),
        .gt (cmp_gt),
        .lt (cmp_lt),
        .eq (cmp_eq)
    );

`ifdef STEP_TIMEOUT_EN
    tmo_cnt_t tmo_cnt;

    // Counts WAIT_DONE cycles; cleared everywhere else so each step gets a fresh budget.
    always_ff @(posedge drv_clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Fires so that FAULT is visible exactly TIMEOUT cycles after the step request.
    assign tmo_hit = (tmo_cnt == tmo_cnt_t'(TIMEOUT - 2));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge drv_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a done arriving on the last allowed cycle still counts as completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept && !cmp_eq) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.done) begin
                    state_nxt = GAP;
                end else if (tmo_hit) begin
                    state_nxt = FAULT;
                end
            end
            GAP:       if (gap_last) state_nxt = cmp_eq ? IDLE : ISSUE;
            FAULT:     state_nxt = FAULT;
            default:   state_nxt = IDLE;
        endcase
    end

    // Target latch, step direction, position update and gap counter.
    always_ff @(posedge drv_clk) begin
        if (reset) begin
            pos_q     <= '0;
            target_q  <= '0;
            dir_fwd_q <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            if (accept) begin
                target_q <= bus.cmd_target;
            end
            if (state == ISSUE) begin
                dir_fwd_q <= cmp_gt;
            end
            if ((state == WAIT_DONE) && bus.done) begin
                pos_q <= dir_fwd_q ? pos_q + 8'd1 : pos_q - 8'd1;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // Outputs decoded from state; step pulses only in ISSUE, direction from a fresh compare.
    always_comb begin
        cmd_ready_o = (state == IDLE) && CFG_OK;
        busy_o      = (state != IDLE);
        forw_o      = (state == ISSUE) && cmp_gt;
        rev_o       = (state == ISSUE) && cmp_lt;
`ifdef STEP_TIMEOUT_EN
        fault_o     = (state == FAULT);
`else
        fault_o     = 1'b0;
`endif
    end

    assign bus.cmd_ready = cmd_ready_o;
    assign bus.busy      = busy_o;
    assign bus.forw      = forw_o;
    assign bus.rev       = rev_o;
    assign bus.fault     = fault_o;
    assign bus.pos       = pos_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: timestamp-based reference model plus directed scenarios.
// Latency: n/a.
// Backpressure: random done latency and stray done pulses from a driver responder.
module tb_step_sequencer;
    import step_seq_pkg::*;

    localparam int G   = 3;
    localparam int TMO = 60;

    logic drv_clk = 1'b0;
    logic reset;
    logic resp_done;
    logic stray_done;
    logic force_done;

    always #5 drv_clk = ~drv_clk;

    step_sequencer_if bus();

    assign bus.done = resp_done | stray_done | force_done;

    step_sequencer #(.STEP_GAP(G), .TIMEOUT(TMO)) dut (
        .drv_clk (drv_clk),
        .reset   (reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a move is a list of scheduled step times, not a state machine.
    bit m_valid      = 0;
    int m_pos        = 0;
    int m_target     = 0;
    bit m_busy       = 0;
    bit m_wait       = 0;
    bit m_fault      = 0;
    int m_dir        = 0;
    int m_issue_at   = -1;
    int m_release_at = -1;
    int m_fwd_cyc    = 0;

    initial forever begin
        @(posedge drv_clk);
        if (reset) begin
            m_valid = 1; m_pos = 0; m_target = 0; m_busy = 0; m_wait = 0;
            m_fault = 0; m_issue_at = -1; m_release_at = -1;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (bus.cmd_valid) begin
                    m_target = int'(bus.cmd_target);
                    if (m_target != m_pos) begin
                        m_busy = 1;
                        m_issue_at = cyc + 1;
                    end
                end
            end else if (m_fault) begin
                m_fault = 1;
            end else if (m_issue_at == cyc) begin
                m_dir = (m_target > m_pos) ? 1 : -1;
                m_wait = 1;
                m_fwd_cyc = cyc;
                m_issue_at = -1;
            end else if (m_wait) begin
                if (bus.done) begin
                    m_pos = m_pos + m_dir;
                    m_wait = 0;
                    if (m_pos != m_target) m_issue_at = cyc + G + 1;
                    else m_release_at = cyc + G + 1;
                end
`ifdef STEP_TIMEOUT_EN
                else if (cyc + 1 - m_fwd_cyc == TMO) begin
                    m_fault = 1;
                    m_wait = 0;
                end
`endif
            end else if (m_release_at == cyc + 1) begin
                m_busy = 0;
                m_release_at = -1;
            end
        end
        cyc++;
    end

    // Monitor statistics used by the directed checks.
    int fwd_cnt = 0, rev_cnt = 0, busy_cnt = 0;
    int accept_cyc = 0, first_lat = -1, gap_meas = -1;
    int last_done_cyc = -1, last_step_cyc = 0, fault_lat = -1;
    bit first_pend = 0, fault_seen = 0;

    // Per-cycle compare against the model, then statistics update.
    initial forever begin
        @(negedge drv_clk);
        if (m_valid) begin
            chk("cmd_ready", int'(bus.cmd_ready), int'(!m_busy));
            chk("busy", int'(bus.busy), int'(m_busy));
            chk("forw", int'(bus.forw), int'(m_busy && m_issue_at == cyc && m_target > m_pos));
            chk("rev", int'(bus.rev), int'(m_busy && m_issue_at == cyc && m_target < m_pos));
            chk("pos", int'(bus.pos), m_pos);
            chk("fault", int'(bus.fault), int'(m_fault));
        end
        if (bus.forw) fwd_cnt++;
        if (bus.rev) rev_cnt++;
        if (bus.busy) busy_cnt++;
        if (bus.cmd_valid && bus.cmd_ready) begin
            accept_cyc = cyc; first_pend = 1; last_done_cyc = -1;
        end
        if (bus.forw || bus.rev) begin
            if (first_pend) begin
                first_lat = cyc - accept_cyc;
                first_pend = 0;
            end else if (last_done_cyc >= 0) begin
                gap_meas = cyc - last_done_cyc;
            end
            last_step_cyc = cyc;
        end
        if (bus.done) last_done_cyc = cyc;
        if (reset) fault_seen = 0;
        else if (bus.fault && !fault_seen) begin
            fault_seen = 1;
            fault_lat = cyc - last_step_cyc;
        end
    end

    // Motor-driver responder: answers each step after 1..5 cycles, optional stray pulses.
    int resp_cnt = 0;
    bit withhold = 0;
    bit stray_en = 0;

    initial begin
        resp_done = 1'b0;
        stray_done = 1'b0;
        forever begin
            @(posedge drv_clk); #1;
            resp_done = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) resp_done = 1'b1;
            end
            if ((bus.forw || bus.rev) && !withhold) resp_cnt = $urandom_range(1, 5);
            stray_done = stray_en && ($urandom_range(0, 9) == 0);
        end
    end

    task automatic cycle();
        @(posedge drv_clk); #1;
    endtask

    task automatic send(input int t);
        bus.cmd_valid = 1'b1;
        bus.cmd_target = 8'(t);
        cycle();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL wait_idle busy still 1 after %0d cycles, required 0", budget);
        end
    endtask

    int f0, r0, b0;

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_target = '0;
        force_done = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;

        // Reset state
        chk("rst_pos", int'(bus.pos), 0);
        chk("rst_ready", int'(bus.cmd_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_forw", int'(bus.forw), 0);
        chk("rst_rev", int'(bus.rev), 0);
        chk("rst_fault", int'(bus.fault), 0);
        cycle();

        // Forward move 0 -> 3
        f0 = fwd_cnt; r0 = rev_cnt;
        send(3);
        wait_idle(200);
        chk("move3_forw", fwd_cnt - f0, 3);
        chk("move3_rev", rev_cnt - r0, 0);
        chk("move3_pos", int'(bus.pos), 3);

        // Reverse move 3 -> 1 with latency and gap timing
        f0 = fwd_cnt; r0 = rev_cnt;
        send(1);
        wait_idle(200);
        chk("move1_rev", rev_cnt - r0, 2);
        chk("move1_forw", fwd_cnt - f0, 0);
        chk("move1_pos", int'(bus.pos), 1);
        chk("first_step_lat", first_lat, 1);
        chk("done_to_step_gap", gap_meas, G + 1);

        // Target equal to position
        f0 = fwd_cnt; r0 = rev_cnt; b0 = busy_cnt;
        send(1);
        repeat (4) cycle();
        chk("eq_busy_cycles", busy_cnt - b0, 0);
        chk("eq_steps", (fwd_cnt - f0) + (rev_cnt - r0), 0);
        chk("eq_pos", int'(bus.pos), 1);

        // Command during a move is dropped; stray done in IDLE is ignored
        send(5);
        repeat (2) cycle();
        bus.cmd_valid = 1'b1;
        bus.cmd_target = 8'd200;
        repeat (6) cycle();
        bus.cmd_valid = 1'b0;
        wait_idle(200);
        chk("ignore_pos", int'(bus.pos), 5);
        force_done = 1'b1;
        cycle();
        force_done = 1'b0;
        cycle();
        chk("stray_pos", int'(bus.pos), 5);

        // Reset while waiting for done
        withhold = 1;
        cycle();
        send(10);
        repeat (2) cycle();
        chk("pre_rst_busy", int'(bus.busy), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midrst_pos", int'(bus.pos), 0);
        chk("midrst_forw", int'(bus.forw), 0);
        chk("midrst_rev", int'(bus.rev), 0);
        chk("midrst_ready", int'(bus.cmd_ready), 1);

`ifdef STEP_TIMEOUT_EN
        // Done withheld -> fault after TIMEOUT cycles, sticky until reset
        cycle();
        send(2);
        for (int n = 0; n < TMO + 20 && !bus.fault; n++) cycle();
        chk("tmo_seen", int'(fault_seen), 1);
        chk("tmo_latency", fault_lat, TMO);
        repeat (5) cycle();
        chk("tmo_hold", int'(bus.fault), 1);
        chk("tmo_busy", int'(bus.busy), 1);
        chk("tmo_ready", int'(bus.cmd_ready), 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("tmo_clear", int'(bus.fault), 0);
`endif
        withhold = 0;
        cycle();

        // Random traffic near 0, with occasional resets
        stray_en = 1;
        for (int i = 0; i < 1500; i++) begin
            bus.cmd_valid = ($urandom_range(0, 3) == 0);
            bus.cmd_target = 8'($urandom_range(0, 15));
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        stray_en = 0;
        wait_idle(300);

        // Climb to the top boundary, then random traffic near 255
        send(250);
        wait_idle(5000);
        chk("climb_pos", int'(bus.pos), 250);
        stray_en = 1;
        for (int i = 0; i < 1500; i++) begin
            bus.cmd_valid = ($urandom_range(0, 3) == 0);
            bus.cmd_target = 8'(240 + $urandom_range(0, 15));
            cycle();
        end
        bus.cmd_valid = 1'b0;
        stray_en = 0;
        wait_idle(300);
        repeat (5) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- STEP_GAP, 4, idle cycles after each completed step before the next step is issued (1..15).
- TIMEOUT, 255, maximum cycles to wait for done after a step request (used only with STEP_TIMEOUT_EN).

REQ-002 The block SHALL have one clock; reset is synchronous and active-high.

REQ-003 Ports SHALL be, one per line:
- drv_clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  a target command is presented.
- cmd_target  in  8  absolute target position, unsigned.
- cmd_ready  out  1  the block accepts a command this cycle.
- forw  out  1  one-step-forward request to the downstream motor driver.
- rev  out  1  one-step-reverse request to the downstream motor driver.
- done  in  1  downstream driver has completed the requested step (one-cycle pulse).
- pos  out  8  current absolute position, unsigned.
- busy  out  1  a move is in progress.
- fault  out  1  step timeout detected (tied 0 without STEP_TIMEOUT_EN).

Function
REQ-004 States SHALL be IDLE, ISSUE, WAIT_DONE, GAP and FAULT.
REQ-005 In IDLE, cmd_ready SHALL be 1 and busy SHALL be 0; in all other states, cmd_ready SHALL be 0.
REQ-006 A command SHALL be accepted on a cycle where cmd_valid=1 and cmd_ready=1; cmd_target is latched into an internal target register.
REQ-007 On acceptance, if target==pos the block SHALL stay in IDLE, issuing no step; otherwise it SHALL go to ISSUE on the next cycle.
REQ-008 In ISSUE, the block SHALL assert forw for exactly one cycle when target>pos, or rev when target<pos, then go to WAIT_DONE.
REQ-009 forw and rev SHALL never be 1 in the same cycle, and SHALL be 0 outside ISSUE.
REQ-010 In WAIT_DONE, done=1 SHALL increment pos (forward) or decrement pos (reverse) on that edge, then go to GAP.
REQ-011 GAP SHALL last exactly STEP_GAP cycles, then go to ISSUE if target!=pos, else to IDLE.
REQ-012 Direction SHALL be recomputed in every ISSUE from the unsigned 8-bit compare of target and pos.
REQ-013 pos SHALL never wrap: no step is issued past 0 or 255, because the target lies in 0..255.
REQ-014 done SHALL be ignored in IDLE, ISSUE, GAP and FAULT.
REQ-015 cmd_valid while busy SHALL be ignored, and the command SHALL NOT be queued.
REQ-016 Step latency SHALL be: accept to first forw/rev = 1 cycle; done to next forw/rev = STEP_GAP+1 cycles.

Reset
REQ-017 reset=1 SHALL force, on the next edge: state=IDLE, pos=0, target=0, forw=0, rev=0, busy=0, fault=0, cmd_ready=1, and clear the gap and timeout counters.
REQ-018 reset SHALL take priority over all other inputs, including mid-move and in FAULT.

Configuration
REQ-019 With STEP_TIMEOUT_EN defined, a counter SHALL run in WAIT_DONE; reaching TIMEOUT cycles without done SHALL enter FAULT.
REQ-020 FAULT SHALL assert fault=1, keep busy=1 and cmd_ready=0, hold pos, and be left only by reset.
REQ-021 Without STEP_TIMEOUT_EN, no timeout counter SHALL exist, WAIT_DONE SHALL wait indefinitely, FAULT SHALL be unreachable, and fault SHALL be 0.

Structure
REQ-022 A shared package step_seq_pkg SHALL hold the state encoding type, the STEP_GAP/TIMEOUT defaults and the 8-bit position type.
REQ-023 One sub-module, pos_cmp, SHALL compute gt/lt/eq of target versus pos (8-bit unsigned subtract with borrow); all other logic stays in step_sequencer.

Verification
REQ-024 reset, then cmd_target=3 -> exactly 3 forw pulses, each answered by done; pos=3; busy falls; no rev.
REQ-025 From pos=3, cmd_target=1 -> 2 rev pulses; pos=1; first rev 1 cycle after accept; gap of STEP_GAP+1 cycles between done and the next rev.
REQ-026 cmd_target equal to pos=1 -> accepted, no forw/rev, busy stays 0.
REQ-027 cmd_valid with target 200 during a move to 5 -> ignored; final pos=5; stray done in IDLE does not change pos.
REQ-028 reset during WAIT_DONE of a move to 10 -> next cycle pos=0, forw=rev=0, cmd_ready=1.
REQ-029 With STEP_TIMEOUT_EN and done withheld -> fault=1 exactly TIMEOUT cycles after forw; stays set until reset.
